mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 21, the memory address width in bits.
REQ-002 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ld_req  input  1  loader write request, level, held until ld_ack.
REQ-005 SHALL have ld_adr  input  ADR_WIDTH  loader write address, stable while ld_req high.
REQ-006 SHALL have ld_data  input  8  loader write data, stable while ld_req high.
REQ-007 SHALL have ld_ack  output  1  one-cycle loader completion pulse.
REQ-008 SHALL have cpu_req  input  1  CPU access request, level, held until cpu_ack.
REQ-009 SHALL have cpu_adr  input  ADR_WIDTH  CPU address, stable while cpu_req high.
REQ-010 SHALL have cpu_write  input  1  CPU access type: 1 write, 0 read.
REQ-011 SHALL have cpu_wdata  input  8  CPU write data.
REQ-012 SHALL have cpu_rdata  output  8  registered CPU read data.
REQ-013 SHALL have cpu_ack  output  1  one-cycle CPU completion pulse.
REQ-014 SHALL have mem_adr  output  ADR_WIDTH, mem_dout  output  8, and mem_din  input  8, the external SRAM address and data buses.
REQ-015 SHALL have mem_drive  output  1 (data bus output enable), mem_oe  output  1, and mem_we  output  1, all active-high.

Function
REQ-016 SHALL implement the states IDLE, SETUP, STROBE, HOLD and DONE; each non-IDLE state SHALL last exactly one cycle in that order, and DONE SHALL be followed by IDLE.
REQ-017 In IDLE with any request high, the block SHALL grant one requester, latch its address, data and type into mem_adr/mem_dout/type registers, and enter SETUP; with no request, it SHALL stay in IDLE.
REQ-018 Loader grants SHALL always be writes.
REQ-019 Latency: a request sampled in IDLE at edge 0 SHALL give SETUP in cycle 1, STROBE in cycle 2, HOLD in cycle 3, and ack in cycle 4; throughput SHALL be one access per 5 cycles.
REQ-020 Write: mem_drive SHALL be high during SETUP, STROBE and HOLD; mem_we SHALL be high only during STROBE; mem_oe SHALL stay low.
REQ-021 Read: mem_oe SHALL be high during STROBE and HOLD; mem_drive and mem_we SHALL stay low; cpu_rdata SHALL capture mem_din at the edge ending HOLD and hold it until the next CPU read completes.
REQ-022 mem_drive and mem_oe SHALL never be high in the same cycle; mem_adr and mem_dout SHALL be constant from SETUP through DONE.
REQ-023 Acks SHALL be decoded from registered state during DONE, for the granted requester only; the requester drops req at the edge ending DONE.
REQ-024 A req still high in the IDLE after its ack SHALL be treated as a new request.
REQ-025 Changes on the inputs of a non-granted or in-flight requester SHALL not affect the current access.
REQ-026 Requests arriving during a non-IDLE state SHALL wait; no request SHALL be dropped.

Reset
REQ-027 Reset SHALL force state IDLE, mem_adr=0, mem_dout=0, cpu_rdata=0, and mem_we=mem_oe=mem_drive=ld_ack=cpu_ack=0 from the cycle after the reset edge, including when asserted mid-access; the interrupted access SHALL not be acked.
REQ-028 Reset SHALL set last-grant to CPU.

Configuration
REQ-029 With MEM_ARB_RR_EN defined, simultaneous requests in IDLE SHALL be granted to the requester not granted last (round-robin), and last-grant SHALL update on every grant.
REQ-030 Without MEM_ARB_RR_EN, the loader SHALL always win simultaneous requests (fixed priority; CPU starvation during continuous loading is permitted), and last-grant logic SHALL be absent.

Verification
REQ-031 Loader write ld_adr=0x00010, ld_data=0xA5 -> mem_we high exactly in cycle 2 with mem_adr=0x00010 and mem_dout=0xA5; ld_ack in cycle 4 only.
REQ-032 Memory model returns 0x3C at 0x1FFFFF; CPU read of 0x1FFFFF -> mem_oe in cycles 2-3, mem_we=0, cpu_rdata=0x3C with cpu_ack in cycle 4.
REQ-033 ld_req and cpu_req rise together 4 times, each re-requesting after its ack -> without the macro: 4 loader grants before any CPU grant; with the macro: grants alternate L,C,L,C....
REQ-034 Reset pulsed during STROBE of a write -> mem_we=0 next cycle, no ack, state IDLE, all outputs 0.
REQ-035 CPU changes cpu_adr from 0x5 to 0x9 during STROBE of a loader write -> loader access unaffected; the CPU access (at 0x9) is granted next, with cpu_ack 5 cycles after ld_ack.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester (loader / CPU) arbiter for an asynchronous SRAM.
//            Every access runs IDLE -> SETUP -> STROBE -> HOLD -> DONE, one
//            cycle per state, so one access completes every five cycles.
//            Address, data and access type are latched at grant time, which
//            isolates the SRAM cycle from later requester input changes.
// Options  : MEM_ARB_RR_EN - when defined, simultaneous requests alternate
//            between loader and CPU (round-robin). When undefined, the loader
//            always wins simultaneous requests.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADR_WIDTH = 21
) (
    input  logic                 clk,
    input  logic                 reset,
    // loader port (writes only)
    input  logic                 ld_req,
    input  logic [ADR_WIDTH-1:0] ld_adr,
    input  logic [7:0]           ld_data,
    output logic                 ld_ack,
    // CPU port
    input  logic                 cpu_req,
    input  logic [ADR_WIDTH-1:0] cpu_adr,
    input  logic                 cpu_write,
    input  logic [7:0]           cpu_wdata,
    output logic [7:0]           cpu_rdata,
    output logic                 cpu_ack,
    // SRAM side
    output logic [ADR_WIDTH-1:0] mem_adr,
    output logic [7:0]           mem_dout,
    input  logic [7:0]           mem_din,
    output logic                 mem_drive,
    output logic                 mem_oe,
    output logic                 mem_we
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_write;      // latched access type of the granted access
    logic                  r_grant_cpu;  // 1: CPU owns the current access, 0: loader
    logic [ADR_WIDTH-1:0]  r_mem_adr;
    logic [7:0]            r_mem_dout;
    logic [7:0]            r_cpu_rdata;

    logic                  w_any_req;
    logic                  w_grant_cpu;
    logic                  w_start;

    logic                  w_mem_drive;
    logic                  w_mem_oe;
    logic                  w_mem_we;
    logic                  w_ld_ack;
    logic                  w_cpu_ack;

    assign w_any_req = ld_req | cpu_req;
    assign w_start   = (r_state == ST_IDLE) && w_any_req;

`ifdef MEM_ARB_RR_EN
    // Remembers who was granted last; resets to CPU so the loader wins the first tie.
    logic r_last_cpu;

    // Last-grant register, updated on every grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_cpu <= 1'b1;
        end else if (w_start) begin
            r_last_cpu <= w_grant_cpu;
        end
    end

    // On a tie the requester that was not granted last wins.
    assign w_grant_cpu = cpu_req && (!ld_req || !r_last_cpu);
`else
    // Fixed priority: the loader wins every tie.
    assign w_grant_cpu = cpu_req && !ld_req;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and SRAM strobe / ack decode from the registered state.
    always_comb begin
        w_state_nxt = r_state;
        w_mem_drive = 1'b0;
        w_mem_oe    = 1'b0;
        w_mem_we    = 1'b0;
        w_ld_ack    = 1'b0;
        w_cpu_ack   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_STROBE;
                w_mem_drive = r_write;
            end
            ST_STROBE: begin
                w_state_nxt = ST_HOLD;
                w_mem_drive = r_write;
                w_mem_we    = r_write;
                w_mem_oe    = !r_write;
            end
            ST_HOLD: begin
                w_state_nxt = ST_DONE;
                w_mem_drive = r_write;
                w_mem_oe    = !r_write;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_ld_ack    = !r_grant_cpu;
                w_cpu_ack   = r_grant_cpu;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the granted requester's address, data and type; they stay frozen
    // until the next grant so the whole SRAM cycle sees stable values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_adr   <= '0;
            r_mem_dout  <= '0;
            r_write     <= 1'b0;
            r_grant_cpu <= 1'b0;
        end else if (w_start) begin
            r_grant_cpu <= w_grant_cpu;
            if (w_grant_cpu) begin
                r_mem_adr  <= cpu_adr;
                r_mem_dout <= cpu_wdata;
                r_write    <= cpu_write;
            end else begin
                r_mem_adr  <= ld_adr;
                r_mem_dout <= ld_data;
                r_write    <= 1'b1;
            end
        end
    end

    // Capture read data at the edge ending HOLD; held until the next CPU read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rdata <= '0;
        end else if ((r_state == ST_HOLD) && r_grant_cpu && !r_write) begin
            r_cpu_rdata <= mem_din;
        end
    end

    assign mem_adr   = r_mem_adr;
    assign mem_dout  = r_mem_dout;
    assign mem_drive = w_mem_drive;
    assign mem_oe    = w_mem_oe;
    assign mem_we    = w_mem_we;
    assign ld_ack    = w_ld_ack;
    assign cpu_ack   = w_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. Covers reset state,
//            loader write timing, CPU read timing, tie arbitration (fixed or
//            round-robin depending on MEM_ARB_RR_EN), reset mid-access and
//            requester input changes during an in-flight access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_AW = 21;

    logic            clk;
    logic            reset;
    logic            ld_req;
    logic [c_AW-1:0] ld_adr;
    logic [7:0]      ld_data;
    logic            ld_ack;
    logic            cpu_req;
    logic [c_AW-1:0] cpu_adr;
    logic            cpu_write;
    logic [7:0]      cpu_wdata;
    logic [7:0]      cpu_rdata;
    logic            cpu_ack;
    logic [c_AW-1:0] mem_adr;
    logic [7:0]      mem_dout;
    logic [7:0]      mem_din;
    logic            mem_drive;
    logic            mem_oe;
    logic            mem_we;

    int n_vec;
    int n_err;

    mem_arbiter #(.ADR_WIDTH(c_AW)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .ld_req    (ld_req),
        .ld_adr    (ld_adr),
        .ld_data   (ld_data),
        .ld_ack    (ld_ack),
        .cpu_req   (cpu_req),
        .cpu_adr   (cpu_adr),
        .cpu_write (cpu_write),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .mem_adr   (mem_adr),
        .mem_dout  (mem_dout),
        .mem_din   (mem_din),
        .mem_drive (mem_drive),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we)
    );

    // SRAM model: 0x3C at the top address, inverted low address byte elsewhere;
    // the bus reads as 0 whenever output enable is low.
    assign mem_din = mem_oe ? ((mem_adr == 21'h1FFFFF) ? 8'h3C : ~mem_adr[7:0]) : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    byte   order [8];
    string exp_order;
    int    g_n;
    int    ld_n;
    int    cpu_n;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        ld_req    = 1'b0;
        ld_adr    = '0;
        ld_data   = '0;
        cpu_req   = 1'b0;
        cpu_adr   = '0;
        cpu_write = 1'b0;
        cpu_wdata = '0;
        tick();
        tick();
        reset = 1'b0;

        // ---------------- reset state
        check_val("rst_adr",   32'(mem_adr),   32'h0);
        check_val("rst_dout",  32'(mem_dout),  32'h0);
        check_val("rst_rdata", 32'(cpu_rdata), 32'h0);
        check_val("rst_ctl",   {29'd0, mem_we, mem_oe, mem_drive}, 32'h0);
        check_val("rst_acks",  {30'd0, ld_ack, cpu_ack}, 32'h0);

        // ---------------- loader write 0x00010 <= 0xA5
        ld_req  = 1'b1;
        ld_adr  = 21'h00010;
        ld_data = 8'hA5;
        tick();  // cycle 1 (SETUP)
        check_val("ldw_c1_ctl", {29'd0, mem_we, mem_oe, mem_drive}, 32'b001);
        tick();  // cycle 2 (STROBE)
        check_val("ldw_c2_ctl",  {29'd0, mem_we, mem_oe, mem_drive}, 32'b101);
        check_val("ldw_c2_adr",  32'(mem_adr),  32'h10);
        check_val("ldw_c2_dout", 32'(mem_dout), 32'hA5);
        check_val("ldw_c2_ack",  {31'd0, ld_ack}, 32'h0);
        tick();  // cycle 3 (HOLD)
        check_val("ldw_c3_ctl", {29'd0, mem_we, mem_oe, mem_drive}, 32'b001);
        check_val("ldw_c3_ack", {31'd0, ld_ack}, 32'h0);
        tick();  // cycle 4 (DONE)
        check_val("ldw_c4_ack", {30'd0, ld_ack, cpu_ack}, 32'b10);
        check_val("ldw_c4_ctl", {29'd0, mem_we, mem_oe, mem_drive}, 32'b000);
        ld_req = 1'b0;
        tick();  // cycle 5 (IDLE)
        check_val("ldw_c5_ack", {31'd0, ld_ack}, 32'h0);

        // ---------------- CPU read of 0x1FFFFF
        cpu_req   = 1'b1;
        cpu_write = 1'b0;
        cpu_adr   = 21'h1FFFFF;
        tick();  // cycle 1
        check_val("rd_c1_ctl", {29'd0, mem_we, mem_oe, mem_drive}, 32'b000);
        tick();  // cycle 2
        check_val("rd_c2_ctl", {29'd0, mem_we, mem_oe, mem_drive}, 32'b010);
        check_val("rd_c2_adr", 32'(mem_adr), 32'h1FFFFF);
        tick();  // cycle 3
        check_val("rd_c3_ctl",   {29'd0, mem_we, mem_oe, mem_drive}, 32'b010);
        check_val("rd_c3_rdata", 32'(cpu_rdata), 32'h0);
        check_val("rd_c3_ack",   {31'd0, cpu_ack}, 32'h0);
        tick();  // cycle 4
        check_val("rd_c4_ack",   {30'd0, ld_ack, cpu_ack}, 32'b01);
        check_val("rd_c4_rdata", 32'(cpu_rdata), 32'h3C);
        check_val("rd_c4_ctl",   {29'd0, mem_we, mem_oe, mem_drive}, 32'b000);
        cpu_req = 1'b0;
        tick();
        check_val("rd_hold_rdata", 32'(cpu_rdata), 32'h3C);

        // ---------------- reset during STROBE of a loader write
        ld_req  = 1'b1;
        ld_adr  = 21'h00123;
        ld_data = 8'h77;
        tick();  // SETUP
        tick();  // STROBE
        check_val("rst_mid_we", {31'd0, mem_we}, 32'h1);
        reset  = 1'b1;
        ld_req = 1'b0;
        tick();
        check_val("rst_mid_ctl",   {29'd0, mem_we, mem_oe, mem_drive}, 32'b000);
        check_val("rst_mid_adr",   32'(mem_adr),   32'h0);
        check_val("rst_mid_dout",  32'(mem_dout),  32'h0);
        check_val("rst_mid_rdata", 32'(cpu_rdata), 32'h0);
        reset = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick();
                seen = seen | ld_ack | cpu_ack | mem_drive | mem_oe;
            end
            check_val("rst_mid_idle", {31'd0, seen}, 32'h0);
        end

        // ---------------- CPU changes address while loader write is in flight
        ld_req    = 1'b1;
        ld_adr    = 21'h00040;
        ld_data   = 8'h11;
        cpu_req   = 1'b1;
        cpu_write = 1'b1;
        cpu_adr   = 21'h00005;
        cpu_wdata = 8'h99;
        tick();  // cycle 1
        tick();  // cycle 2 (STROBE of loader write)
        cpu_adr = 21'h00009;
        check_val("chg_c2_adr", 32'(mem_adr), 32'h40);
        tick();  // cycle 3
        check_val("chg_c3_adr",  32'(mem_adr),  32'h40);
        check_val("chg_c3_dout", 32'(mem_dout), 32'h11);
        tick();  // cycle 4
        check_val("chg_c4_ack", {30'd0, ld_ack, cpu_ack}, 32'b10);
        ld_req = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 3) begin
                check_val("chg_cpu_adr",  32'(mem_adr),  32'h9);
                check_val("chg_cpu_dout", 32'(mem_dout), 32'h99);
                check_val("chg_cpu_we",   {31'd0, mem_we}, 32'h1);
            end
            check_val("chg_cpu_ack", {31'd0, cpu_ack}, (i == 5) ? 32'h1 : 32'h0);
        end
        cpu_req = 1'b0;
        tick();

        // ---------------- simultaneous requests, four each
`ifdef MEM_ARB_RR_EN
        exp_order = "LCLCLCLC";
`else
        exp_order = "LLLLCCCC";
`endif
        g_n       = 0;
        ld_n      = 0;
        cpu_n     = 0;
        ld_adr    = 21'h00100;
        cpu_adr   = 21'h00200;
        cpu_write = 1'b1;
        ld_req    = 1'b1;
        cpu_req   = 1'b1;
        for (int c = 0; c < 80 && g_n < 8; c++) begin
            tick();
            check_val("excl_drive_oe", {31'd0, mem_drive & mem_oe}, 32'h0);
            if (ld_ack) begin
                order[g_n] = "L";
                g_n        = g_n + 1;
                ld_n       = ld_n + 1;
                ld_req     = 1'b0;
            end else if (!ld_req && ld_n < 4) begin
                ld_req = 1'b1;
            end
            if (cpu_ack) begin
                order[g_n] = "C";
                g_n        = g_n + 1;
                cpu_n      = cpu_n + 1;
                cpu_req    = 1'b0;
            end else if (!cpu_req && cpu_n < 4) begin
                cpu_req = 1'b1;
            end
        end
        ld_req  = 1'b0;
        cpu_req = 1'b0;
        check_val("tie_grants", 32'(g_n), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < g_n) begin
                check_val($sformatf("tie_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
